// File: rtl/multicycle_control.sv
// Purpose : main control FSM of the multicycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Latency : 3 cycles (BEQ, J), 4 cycles (R-type, ADDI, ORI, SW) and 5 cycles (LW) with zero-wait memory.
// Backpres: mem_ready=0 holds FETCH, MEM_READ and MEM_WRITE; each stalled cycle adds one cycle.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   opcode            IR[31:26], sampled into op_q in DECODE
//   mem_ready         memory access completes in the current cycle
//   PCWrite .. PCSource  datapath mux selects and write enables, decoded from state
//   instr_done        one-cycle pulse in the last state of each instruction
//   illegal_op        sticky: an unsupported opcode reached DECODE since the last reset
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_ORI   = 6'b001101,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_I_EXEC    = 4'd9,
        ST_I_WB      = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12
    } state_t;

    // ALUOp encodings seen by the ALU control unit
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_RT  = 3'b111;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] op_q;
    logic       op_legal;

    // Opcode is only trusted in DECODE; later states use the latched copy so
    // the IR source may change freely after decode.
    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
            default:                                               op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= 6'd0;
            illegal_op <= 1'b0;
        end else if (state == ST_DECODE) begin
            op_q <= opcode;
            if (!op_legal) begin
                illegal_op <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = ST_FETCH;
        case (state)
            ST_RST:   state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:    state_nxt = ST_MEM_ADDR;
                    OP_RTYPE:        state_nxt = ST_R_EXEC;
                    OP_ADDI, OP_ORI: state_nxt = ST_I_EXEC;
                    OP_BEQ:          state_nxt = ST_BRANCH;
                    OP_J:            state_nxt = ST_JUMP;
                    default:         state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR:  state_nxt = (op_q == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  state_nxt = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    state_nxt = ST_FETCH;
            ST_MEM_WRITE: state_nxt = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_R_EXEC:    state_nxt = ST_R_WB;
            ST_R_WB:      state_nxt = ST_FETCH;
            ST_I_EXEC:    state_nxt = ST_I_WB;
            ST_I_WB:      state_nxt = ST_FETCH;
            ST_BRANCH:    state_nxt = ST_FETCH;
            ST_JUMP:      state_nxt = ST_FETCH;
            // Unused encodings recover through FETCH with every output idle
            default:      state_nxt = ST_FETCH;
        endcase
    end

    // Output decode: Moore outputs, except the FETCH load enables and the
    // MEM_WRITE completion pulse, which wait for the memory handshake.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        case (state)
            ST_FETCH: begin
                // PC+4 computed on the shared ALU while the instruction is read
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut
                ALUSrcB = 2'b11;
                ALUOp   = ALU_ADD;
            end
            ST_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_ADD;
            end
            ST_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            ST_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_RT;
            end
            ST_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            ST_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (op_q == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            ST_I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                // rs - rt; the PC takes the decode-time target only on zero
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            ST_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aop;
        logic [1:0] psrc;
        logic       done;
        logic       ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done, illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    ctl_t  exp_q[$];
    string nm_q[$];
    logic  ill_m = 1'b0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_ADDI || op == OP_ORI || op == OP_LW ||
               op == OP_SW || op == OP_BEQ || op == OP_J;
    endfunction

    // Idle control word carrying the model's sticky illegal flag
    function automatic ctl_t base();
        ctl_t c;
        c     = '0;
        c.ill = ill_m;
        return c;
    endfunction

    // One clock cycle: drive inputs just after the edge, record what the
    // control outputs must look like before the next edge.
    task automatic step(input ctl_t e, input string nm, input logic [5:0] opc,
                        input logic mr, input logic rs);
        reset     = rs;
        opcode    = opc;
        mem_ready = mr;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles(input int n, input string nm);
        for (int i = 0; i < n; i++) step('0, nm, rnd6(), rnd1(), 1'b0);
        step('0, {nm, "_release"}, rnd6(), rnd1(), 1'b1);
    endtask

    // Reference model: expands one instruction into its per-cycle control words.
    // fs/ms are stall cycles in the fetch and data-memory steps; abort asserts
    // reset in the first stalled cycle of a store.
    task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input logic abort);
        ctl_t c;
        for (int i = 0; i < fs; i++) begin
            c = base(); c.mrd = 1; c.srcb = 2'b01; c.aop = 3'b100;
            step(c, "fetch_stall", rnd6(), 1'b0, 1'b1);
        end
        c = base(); c.mrd = 1; c.srcb = 2'b01; c.aop = 3'b100; c.irw = 1; c.pcw = 1;
        step(c, "fetch", rnd6(), 1'b1, 1'b1);
        c = base(); c.srcb = 2'b11; c.aop = 3'b100;
        step(c, "decode", op, rnd1(), 1'b1);
        if (!legal(op)) begin
            ill_m = 1'b1;
            return;
        end
        case (op)
            OP_LW, OP_SW: begin
                c = base(); c.srca = 1; c.srcb = 2'b10; c.aop = 3'b100;
                step(c, "mem_addr", rnd6(), rnd1(), 1'b1);
                if (op == OP_LW) begin
                    for (int i = 0; i < ms; i++) begin
                        c = base(); c.mrd = 1; c.iord = 1;
                        step(c, "mem_read_stall", rnd6(), 1'b0, 1'b1);
                    end
                    c = base(); c.mrd = 1; c.iord = 1;
                    step(c, "mem_read", rnd6(), 1'b1, 1'b1);
                    c = base(); c.rw = 1; c.m2r = 1; c.done = 1;
                    step(c, "mem_wb", rnd6(), rnd1(), 1'b1);
                end else begin
                    for (int i = 0; i < ms; i++) begin
                        c = base(); c.mwr = 1; c.iord = 1;
                        step(c, "mem_write_stall", rnd6(), 1'b0, 1'b1);
                        if (abort) begin
                            ill_m = 1'b0;
                            reset_cycles(2, "abort_reset");
                            return;
                        end
                    end
                    c = base(); c.mwr = 1; c.iord = 1; c.done = 1;
                    step(c, "mem_write", rnd6(), 1'b1, 1'b1);
                end
            end
            OP_RTYPE: begin
                c = base(); c.srca = 1; c.aop = 3'b111;
                step(c, "r_exec", rnd6(), rnd1(), 1'b1);
                c = base(); c.rw = 1; c.rdst = 1; c.done = 1;
                step(c, "r_wb", rnd6(), rnd1(), 1'b1);
            end
            OP_ADDI, OP_ORI: begin
                c = base(); c.srca = 1; c.srcb = 2'b10;
                c.aop = (op == OP_ORI) ? 3'b101 : 3'b100;
                step(c, "i_exec", rnd6(), rnd1(), 1'b1);
                c = base(); c.rw = 1; c.done = 1;
                step(c, "i_wb", rnd6(), rnd1(), 1'b1);
            end
            OP_BEQ: begin
                c = base(); c.srca = 1; c.aop = 3'b110; c.pcwc = 1; c.psrc = 2'b01; c.done = 1;
                step(c, "branch", rnd6(), rnd1(), 1'b1);
            end
            default: begin
                c = base(); c.pcw = 1; c.psrc = 2'b10; c.done = 1;
                step(c, "jump", rnd6(), rnd1(), 1'b1);
            end
        endcase
    endtask

    // Monitor: every cycle the DUT presents a control word; compare it with
    // the oldest expectation.
    initial begin
        ctl_t  a;
        ctl_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                a  = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                       RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
                       illegal_op};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got %b required %b (pcw pcwc iord mrd mwr irw m2r rdst rw srca srcb aop psrc done ill)",
                             nm, $time, a, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        int         r;
        int         fs;
        int         ms;
        reset     = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        reset_cycles(2, "reset");

        // Directed sequences
        run_instr(OP_RTYPE, 0, 0, 1'b0);
        run_instr(OP_LW, 0, 2, 1'b0);
        run_instr(OP_ORI, 0, 0, 1'b0);
        run_instr(OP_ADDI, 0, 0, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(OP_J, 0, 0, 1'b0);
        run_instr(OP_SW, 1, 1, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(OP_RTYPE, 0, 0, 1'b0);
        run_instr(OP_LW, 2, 0, 1'b0);
        run_instr(OP_SW, 0, 2, 1'b1);
        run_instr(OP_J, 0, 0, 1'b0);

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       op = OP_RTYPE;
                1:       op = OP_ADDI;
                2:       op = OP_ORI;
                3:       op = OP_LW;
                4:       op = OP_SW;
                5:       op = OP_BEQ;
                6:       op = OP_J;
                default: op = rnd6();
            endcase
            fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            ms = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(op, fs, ms, (op == OP_SW) && (ms > 0) && ($urandom_range(0, 7) == 0));
        end

        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
